fp_norm_seq: RTL and testbench
==============================

Name: fp_norm_seq

Overview:
- Multi-cycle normalization sequencer for the FP adder's post-add stage.
- Accepts the raw 24-bit significand sum, the carry-out, and the exponent, then computes the leading-zero count with the combinational 24-bit leading-zero detector.
- Left-shifts the significand in bounded steps over several cycles and adjusts the exponent.
- Returns a normalized significand with zero/overflow/underflow flags through valid/ready handshakes on both sides.

Parameters:
- MANT_W, 24, significand width including hidden bit; leading-zero detector is sized for 24.
- EXP_W, 8, biased exponent width.
- LZ_W, 5, width of leading-zero count and shift counters.
- SHIFT_STEP, 8, maximum left-shift distance applied per SHIFT cycle; must be 1..MANT_W-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  sequencer idle and able to accept; equals (state==IDLE), combinational.
- in_carry  in  1  carry-out of the significand adder.
- in_mant  in  MANT_W  raw significand sum.
- in_exp  in  EXP_W  exponent of the larger operand (biased).
- in_sign  in  1  result sign, passed through.
- out_valid  out  1  result valid, registered.
- out_ready  in  1  consumer accepts result.
- out_mant  out  MANT_W  normalized significand; bit MANT_W-1 is set unless a flag forces 0.
- out_exp  out  EXP_W  adjusted exponent.
- out_sign  out  1  captured sign.
- out_lz  out  LZ_W  total left-shift applied; 0 on carry or special cases.
- out_zero  out  1  result is exact zero.
- out_ovf  out  1  exponent overflow; result is infinity.
- out_unf  out  1  exponent underflow; result flushed to zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all output registers, counters and flags = 0.
  - out_valid=0; in_ready=1 while rst_n=0 and after release.
  - Reset mid-operation discards the transaction; no output is produced.
- States: IDLE, DETECT, SHIFT, DONE.
- IDLE:
  - in_valid & in_ready at an edge captures mant, exp, sign and carry into working registers.
  - Next state is DETECT.
- DETECT (exactly one cycle): the leading-zero detector operates on the working mantissa. Priority order:
  - carry=1 and exp+1 == all-ones: ovf=1, exp=all-ones, mant=0, lz=0; go to DONE.
  - carry=1 otherwise: mant = {1, mant[MANT_W-1:1]}, exp = exp+1, lz=0; go to DONE.
  - mant==0: zero=1, exp=0, lz=0; go to DONE.
  - lz >= exp (unsigned): unf=1, mant=0, exp=0, lz=0; go to DONE.
  - lz==0: go to DONE.
  - Otherwise: exp = exp-lz, out_lz = lz, remaining = lz; go to SHIFT.
- SHIFT:
  - Each cycle: d = min(remaining, SHIFT_STEP); mant <<= d; remaining -= d.
  - When remaining becomes 0, go to DONE.
  - Cycle count is ceil(lz / SHIFT_STEP).
- DONE:
  - out_valid=1; out_* held stable until out_ready=1.
  - On out_valid & out_ready, next state is IDLE and out_valid clears.
  - Same-cycle accept of a new input is not allowed, because in_ready=0 in DONE.
- Latency, counted from the accepting edge to out_valid visible: 2 edges + ceil(lz / SHIFT_STEP).
- Minimum initiation interval is 3 cycles.
- Flags out_zero, out_ovf and out_unf are mutually exclusive.
- No rounding; the sticky/guard bits are out of scope.
- in_* inputs are ignored outside IDLE.

Test Plan:
- mant=0x800000, exp=0x80, carry=0 → out_mant=0x800000, out_exp=0x80, out_lz=0, all flags 0; out_valid two edges after accept.
- mant=0x000010, exp=0x80, SHIFT_STEP=8 → three SHIFT cycles (8, 8, 3); out_mant=0x800000, out_exp=0x6D, out_lz=19; latency 5.
- carry=1, mant=0xC00000, exp=0x80 → out_mant=0xE00000, out_exp=0x81; repeat with exp=0xFE → out_ovf=1, out_exp=0xFF, out_mant=0.
- mant=0x000000, carry=0 → out_zero=1, out_exp=0, out_mant=0, latency 2. Separately, mant=0x002000 (lz=10), exp=0x05 → out_unf=1, out_exp=0, out_mant=0.
- Hold out_ready=0 for 4 cycles after out_valid → out_* stable, in_ready=0, busy=1; raise out_ready → IDLE next edge, in_ready=1.
- Assert rst_n=0 during the second SHIFT cycle of a lz=19 transaction → out_valid=0 and in_ready=1 immediately (asynchronous); after release a new input (mant=0x400000, exp=0x10) yields out_mant=0x800000, out_exp=0x0F.

Source files
------------

// File: rtl/fp_norm_seq.sv
// fp_norm_seq: multi-cycle post-add normalizer (LZD, stepped left shift, exponent adjust, flags)
// Valid/ready on both sides; one transaction in flight, results held in DONE until consumed.
module fp_norm_seq #(
    parameter int MANT_W     = 24,
    parameter int EXP_W      = 8,
    parameter int LZ_W       = 5,
    parameter int SHIFT_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_carry_i,
    input  logic [MANT_W-1:0] in_mant_i,
    input  logic [EXP_W-1:0]  in_exp_i,
    input  logic              in_sign_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [MANT_W-1:0] out_mant_o,
    output logic [EXP_W-1:0]  out_exp_o,
    output logic              out_sign_o,
    output logic [LZ_W-1:0]   out_lz_o,
    output logic              out_zero_o,
    output logic              out_ovf_o,
    output logic              out_unf_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [LZ_W-1:0]   lz_q, lz_d, rem_q, rem_d;
    logic              sign_q, sign_d, carry_q, carry_d;
    logic              zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [LZ_W-1:0]   lz_c, step_c;
    logic [EXP_W-1:0]  exp_inc_c;

    // Highest set bit wins because the scan runs from LSB upward; all-zero yields MANT_W.
    always_comb begin
        lz_c = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (mant_q[i]) lz_c = LZ_W'(MANT_W - 1 - i);
    end

    assign step_c    = (rem_q < LZ_W'(SHIFT_STEP)) ? rem_q : LZ_W'(SHIFT_STEP);
    assign exp_inc_c = exp_q + EXP_W'(1);

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        lz_d    = lz_q;
        rem_d   = rem_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = DETECT;
                mant_d  = in_mant_i;
                exp_d   = in_exp_i;
                sign_d  = in_sign_i;
                carry_d = in_carry_i;
                lz_d    = '0;
                rem_d   = '0;
                zero_d  = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            DETECT: begin
                state_d = DONE;
                if (carry_q && exp_inc_c == '1) begin
                    ovf_d  = 1'b1;
                    exp_d  = '1;
                    mant_d = '0;
                end else if (carry_q) begin
                    mant_d = {1'b1, mant_q[MANT_W-1:1]};
                    exp_d  = exp_inc_c;
                end else if (mant_q == '0) begin
                    zero_d = 1'b1;
                    exp_d  = '0;
                end else if (EXP_W'(lz_c) >= exp_q) begin
                    unf_d  = 1'b1;
                    mant_d = '0;
                    exp_d  = '0;
                end else if (lz_c != '0) begin
                    state_d = SHIFT;
                    exp_d   = exp_q - EXP_W'(lz_c);
                    lz_d    = lz_c;
                    rem_d   = lz_c;
                end
            end
            SHIFT: begin
                mant_d  = mant_q << step_c;
                rem_d   = rem_q - step_c;
                state_d = (rem_q == step_c) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            lz_q    <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            lz_q    <= lz_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_mant_o  = mant_q;
    assign out_exp_o   = exp_q;
    assign out_sign_o  = sign_q;
    assign out_lz_o    = lz_q;
    assign out_zero_o  = zero_q;
    assign out_ovf_o   = ovf_q;
    assign out_unf_o   = unf_q;
endmodule

// File: tb/tb_fp_norm_seq.sv
// tb_fp_norm_seq: directed checks of fp_norm_seq with hand-computed results and latencies
module tb_fp_norm_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_carry = 1'b0, in_sign = 1'b0;
    logic [23:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign, out_zero, out_ovf, out_unf, busy;
    logic [4:0]  out_lz;
    int          total = 0, bad = 0, lat;

    fp_norm_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_carry_i(in_carry),
        .in_mant_i(in_mant), .in_exp_i(in_exp), .in_sign_i(in_sign),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_mant_o(out_mant), .out_exp_o(out_exp), .out_sign_o(out_sign),
        .out_lz_o(out_lz), .out_zero_o(out_zero), .out_ovf_o(out_ovf),
        .out_unf_o(out_unf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // {sign, mant, exp, lz, zero, ovf, unf}
    function automatic logic [40:0] res();
        return {out_sign, out_mant, out_exp, out_lz, out_zero, out_ovf, out_unf};
    endfunction

    task automatic issue(input logic [23:0] m, input logic [7:0] e, input logic c, input logic s);
        @(negedge clk);
        in_valid = 1'b1; in_mant = m; in_exp = e; in_carry = c; in_sign = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts edges from the accepting edge through the one that raises out_valid
    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 30) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({out_valid, in_ready, busy, res()} !== {3'b010, 41'd0}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", {out_valid, in_ready, busy, res()}, {3'b010, 41'd0});
        end
        @(negedge clk) rst_n = 1'b1;
        #1 total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release got=%b want=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_passthrough();
        issue(24'h800000, 8'h80, 1'b0, 1'b1);
        wait_valid(lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL pass_latency got=%0d want=2", lat); end
        total++;
        if (res() !== {1'b1, 24'h800000, 8'h80, 5'd0, 3'b000}) begin
            bad++;
            $display("FAIL pass_result got=%h want=%h", res(), {1'b1, 24'h800000, 8'h80, 5'd0, 3'b000});
        end
        drain();
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL pass_drain got=%b want=100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_multi_shift();
        issue(24'h000010, 8'h80, 1'b0, 1'b0);
        wait_valid(lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL shift_latency got=%0d want=5", lat); end
        total++;
        if (res() !== {1'b0, 24'h800000, 8'h6D, 5'd19, 3'b000}) begin
            bad++;
            $display("FAIL shift_result got=%h want=%h", res(), {1'b0, 24'h800000, 8'h6D, 5'd19, 3'b000});
        end
        drain();
    endtask

    task automatic test_carry();
        issue(24'hC00000, 8'h80, 1'b1, 1'b0);
        wait_valid(lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL carry_latency got=%0d want=2", lat); end
        total++;
        if (res() !== {1'b0, 24'hE00000, 8'h81, 5'd0, 3'b000}) begin
            bad++;
            $display("FAIL carry_result got=%h want=%h", res(), {1'b0, 24'hE00000, 8'h81, 5'd0, 3'b000});
        end
        drain();
        issue(24'hC00000, 8'hFE, 1'b1, 1'b1);
        wait_valid(lat);
        total++;
        if (res() !== {1'b1, 24'h000000, 8'hFF, 5'd0, 3'b010}) begin
            bad++;
            $display("FAIL ovf_result got=%h want=%h", res(), {1'b1, 24'h000000, 8'hFF, 5'd0, 3'b010});
        end
        drain();
    endtask

    task automatic test_zero_unf();
        issue(24'h000000, 8'h80, 1'b0, 1'b0);
        wait_valid(lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", lat); end
        total++;
        if (res() !== {1'b0, 24'h000000, 8'h00, 5'd0, 3'b100}) begin
            bad++;
            $display("FAIL zero_result got=%h want=%h", res(), {1'b0, 24'h000000, 8'h00, 5'd0, 3'b100});
        end
        drain();
        issue(24'h002000, 8'h05, 1'b0, 1'b0);
        wait_valid(lat);
        total++;
        if (res() !== {1'b0, 24'h000000, 8'h00, 5'd0, 3'b001}) begin
            bad++;
            $display("FAIL unf_result got=%h want=%h", res(), {1'b0, 24'h000000, 8'h00, 5'd0, 3'b001});
        end
        drain();
    endtask

    task automatic test_backpressure();
        issue(24'h400000, 8'h10, 1'b0, 1'b1);
        wait_valid(lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", lat); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 total++;
            if ({out_valid, in_ready, busy, res()} !== {3'b101, 1'b1, 24'h800000, 8'h0F, 5'd1, 3'b000}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%h want=%h", k, {out_valid, in_ready, busy, res()},
                         {3'b101, 1'b1, 24'h800000, 8'h0F, 5'd1, 3'b000});
            end
        end
        drain();
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL bp_release got=%b want=100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_async_reset();
        issue(24'h000010, 8'h80, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL async_reset got=%b want=010", {out_valid, in_ready, busy});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 total++;
            if ({out_valid, in_ready} !== 2'b01) begin
                bad++;
                $display("FAIL async_idle[%0d] got=%b want=01", k, {out_valid, in_ready});
            end
        end
        issue(24'h400000, 8'h10, 1'b0, 1'b0);
        wait_valid(lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL async_next_latency got=%0d want=3", lat); end
        total++;
        if (res() !== {1'b0, 24'h800000, 8'h0F, 5'd1, 3'b000}) begin
            bad++;
            $display("FAIL async_next_result got=%h want=%h", res(), {1'b0, 24'h800000, 8'h0F, 5'd1, 3'b000});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_multi_shift();
        test_carry();
        test_zero_unf();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
